bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 116 +++++++++++
 tb/tb_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with per-owner hold limit, lock override and forced release.
// One-hot grant is registered; every release is followed by at least one idle (turnaround) cycle.
module bus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int IW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  lock,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          busy,
  output logic          timeout
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  state_t        state, state_nxt;
  logic [7:0]    cnt, cnt_nxt;
  logic [IW-1:0] last, last_nxt;
  logic [IW-1:0] gnt_id_nxt;
  logic [N-1:0]  gnt_nxt;
  logic          timeout_nxt;
  logic [IW-1:0] pick;
  logic [IW-1:0] idx;
  logic          found;
  logic          other_req;

  // Round-robin search: first requester strictly after "last", wrapping modulo N.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(last) + i) % N);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign other_req = |(req & ~gnt);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    gnt_id_nxt  = gnt_id;
    cnt_nxt     = cnt;
    last_nxt    = last;
    timeout_nxt = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt    = '0;
        gnt_nxt    = '0;
        gnt_id_nxt = '0;
        if (found) begin
          state_nxt     = OWN;
          gnt_nxt[pick] = 1'b1;
          gnt_id_nxt    = pick;
          last_nxt      = pick;
        end
      end

      OWN: begin
        if (!req[gnt_id]) begin
          // Voluntary release wins over a coinciding forced release.
          state_nxt  = IDLE;
          gnt_nxt    = '0;
          gnt_id_nxt = '0;
          cnt_nxt    = '0;
        end else if (cnt == HOLD_LIMIT) begin
          if (!lock[gnt_id] && other_req) begin
            state_nxt   = IDLE;
            gnt_nxt     = '0;
            gnt_id_nxt  = '0;
            cnt_nxt     = '0;
            timeout_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      cnt     <= '0;
      last    <= IW'(N - 1);
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      gnt_id  <= gnt_id_nxt;
      busy    <= |gnt_nxt;
      timeout <= timeout_nxt;
      cnt     <= cnt_nxt;
      last    <= last_nxt;
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (clr) $onehot0(gnt));

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (N=4, MAX_HOLD=8): directed scenarios plus
// randomized traffic compared against a cycle-level behavioural model.
module tb_bus_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic         clk;
  logic         clr;
  logic [N-1:0] req;
  logic [N-1:0] lock;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         timeout;

  int checks = 0;
  int errors = 0;

  // Behavioural model: owner index (-1 = bus free), cycles owned so far, last grantee, timeout pulse.
  int m_owner;
  int m_held;
  int m_last;
  bit m_to;

  bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .clr     (clr),
    .req     (req),
    .lock    (lock),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = N - 1;
    m_to    = 1'b0;
  endtask

  task automatic model_step();
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (req != '0) begin
        for (int i = 1; i <= N; i++) begin
          if (m_owner < 0 && req[(m_last + i) % N]) m_owner = (m_last + i) % N;
        end
        m_last = m_owner;
        m_held = 1;
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
      m_held  = 0;
    end else if (m_held >= MAX_HOLD && !lock[m_owner] && (req & ~(4'b0001 << m_owner)) != '0) begin
      m_owner = -1;
      m_held  = 0;
      m_to    = 1'b1;
    end else begin
      m_held++;
    end
  endtask

  // Advance one clock edge and settle; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    if (!clr) model_step();
    #1;
  endtask

  task automatic pulse_clr();
    #3 clr = 1'b1;
    model_reset();
    #2 clr = 1'b0;
  endtask

  task automatic test_reset();
    req  = '0;
    lock = '0;
    clr  = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt_id: got %0d expected 0", gnt_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    #3 clr = 1'b0;
  endtask

  task automatic test_first_grant();
    req = 4'b0101;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL first_gnt: got %b expected 0001", gnt); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL first_gnt_id: got %0d expected 0", gnt_id); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy: got %b expected 1", busy); end
  endtask

  task automatic test_release();
    req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL release_turnaround: got %b expected 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy: got %b expected 0", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL release_timeout: got %b expected 0", timeout); end
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL release_next_gnt: got %b expected 0100", gnt); end
    checks++; if (gnt_id !== 2'd2) begin errors++; $display("FAIL release_next_id: got %0d expected 2", gnt_id); end
  endtask

  task automatic test_rotation();
    int order[5] = '{0, 1, 2, 3, 0};
    int got[$];
    logic [N-1:0] prev;
    pulse_clr();
    req  = 4'b1111;
    lock = '0;
    prev = '0;
    for (int c = 0; c < 200 && got.size() < 5; c++) begin
      tick();
      if (gnt != '0 && prev != '0 && gnt != prev) begin
        checks++; errors++;
        $display("FAIL rotation_turnaround: got %b after %b expected an idle cycle", gnt, prev);
      end
      if (gnt != '0 && prev == '0) got.push_back(int'(gnt_id));
      prev = gnt;
    end
    checks++;
    if (got.size() != 5) begin
      errors++; $display("FAIL rotation_count: got %0d grants expected 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got[i] != order[i]) begin
          errors++; $display("FAIL rotation_order[%0d]: got %0d expected %0d", i, got[i], order[i]);
        end
      end
    end
  endtask

  task automatic test_hold_alone();
    int bad_gnt = 0;
    int bad_to  = 0;
    pulse_clr();
    req  = 4'b0100;
    lock = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (gnt !== 4'b0100) bad_gnt++;
      if (timeout !== 1'b0) bad_to++;
    end
    checks++; if (bad_gnt != 0) begin errors++; $display("FAIL hold_alone_gnt: got %0d bad cycles expected 0", bad_gnt); end
    checks++; if (bad_to != 0) begin errors++; $display("FAIL hold_alone_timeout: got %0d pulses expected 0", bad_to); end
  endtask

  task automatic grant_owner1();
    pulse_clr();
    lock = '0;
    req  = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL owner1_gnt: got %b expected 0010", gnt); end
    req = 4'b0011;
  endtask

  task automatic test_forced_release();
    int bad = 0;
    grant_owner1();
    repeat (MAX_HOLD - 1) begin
      tick();
      if (gnt !== 4'b0010 || timeout !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL forced_hold: got %0d bad cycles expected 0", bad); end
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL forced_gnt: got %b expected 0000", gnt); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL forced_timeout: got %b expected 1", timeout); end
    tick();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL forced_pulse_width: got %b expected 0", timeout); end
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL forced_next_gnt: got %b expected 0001", gnt); end
  endtask

  task automatic test_lock();
    int bad = 0;
    grant_owner1();
    lock = 4'b0010;
    repeat (12) begin
      tick();
      if (gnt !== 4'b0010 || timeout !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL lock_hold: got %0d bad cycles expected 0", bad); end
    lock = '0;
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL lock_drop_gnt: got %b expected 0000", gnt); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL lock_drop_timeout: got %b expected 1", timeout); end
  endtask

  task automatic test_release_priority();
    grant_owner1();
    repeat (MAX_HOLD - 1) tick();
    req = 4'b0001;
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL prio_gnt: got %b expected 0000", gnt); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL prio_timeout: got %b expected 0", timeout); end
  endtask

  task automatic test_clr_mid_grant();
    grant_owner1();
    repeat (2) tick();
    #3 clr = 1'b1;
    model_reset();
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL clr_async_gnt: got %b expected 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_async_busy: got %b expected 0", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL clr_async_timeout: got %b expected 0", timeout); end
    #2 clr = 1'b0;
    req = 4'b1000;
    tick();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL clr_regrant_gnt: got %b expected 1000", gnt); end
    checks++; if (gnt_id !== 2'd3) begin errors++; $display("FAIL clr_regrant_id: got %0d expected 3", gnt_id); end
  endtask

  task automatic test_random();
    logic [N-1:0] exp_gnt;
    logic [1:0]   exp_id;
    int           err0;
    pulse_clr();
    req  = '0;
    lock = '0;
    err0 = errors;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      if ($urandom_range(0, 7) == 0) lock = 4'($urandom);
      if ($urandom_range(0, 499) == 0) pulse_clr();
      tick();
      exp_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      exp_id  = (m_owner < 0) ? 2'd0 : 2'(m_owner);
      if (errors - err0 < 10) begin
        checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rand_gnt cycle %0d: got %b expected %b", c, gnt, exp_gnt); end
        checks++; if (gnt_id !== exp_id) begin errors++; $display("FAIL rand_gnt_id cycle %0d: got %0d expected %0d", c, gnt_id, exp_id); end
        checks++; if (busy !== (m_owner >= 0)) begin errors++; $display("FAIL rand_busy cycle %0d: got %b expected %b", c, busy, m_owner >= 0); end
        checks++; if (timeout !== m_to) begin errors++; $display("FAIL rand_timeout cycle %0d: got %b expected %b", c, timeout, m_to); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_release();
    test_rotation();
    test_hold_alone();
    test_forced_release();
    test_lock();
    test_release_priority();
    test_clr_mid_grant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
